register_file_mc: RTL and testbench

- Clocked, parametrised successor to the p2p plugin's latch-based register file.
- Holds ENTRIES configuration words, written and read by the system (AXI-lite register) side, and read concurrently by NUM_CLIENTS internal datapath clients (e.g. both CMAC paths).
- Adds byte write strobes, a read-only mask, registered read latency with valid flags, out-of-range detection and per-entry update pulses.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_read_port.sv | 38 +++
 rtl/register_file_mc.sv | 137 +++++++++++++
 tb/tb_register_file_mc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the p2p plugin register file: a clog2 helper that
// never collapses to zero width, and the data returned for out-of-range reads.
package regfile_pkg;

   localparam logic ERR_DATA_BIT = 1'b0;

   function automatic int addr_width(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range-checked word select from the register array,
// a one-cycle valid pulse, and data held between requests.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int ENTRIES    = 12,
   parameter int DATA_WIDTH = 32,
   parameter int AW         = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [ENTRIES-1:0][DATA_WIDTH-1:0] words,
   input  logic                              rd,
   input  logic [AW-1:0]                     addr,
   output logic [DATA_WIDTH-1:0]             dout,
   output logic                              rvalid
);

   logic [DATA_WIDTH-1:0] sel;

   // Addresses past ENTRIES match no word and fall through to the error value.
   always_comb begin
      sel = {DATA_WIDTH{ERR_DATA_BIT}};
      for (int i = 0; i < ENTRIES; i++)
         if (int'(addr) == i) sel = words[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout   <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= rd;
         if (rd) dout <= sel;
      end
   end

endmodule

// File: rtl/register_file_mc.sv
// Multi-client configuration register file with byte strobes and a read-only mask.
// Optional macro REGFILE_SHADOW_EN adds a shadow array and an atomic commit input.
module register_file_mc
   import regfile_pkg::*;
#(
   parameter int                  ENTRIES     = 12,
   parameter int                  DATA_WIDTH  = 32,
   parameter int                  NUM_CLIENTS = 2,
   parameter logic [ENTRIES-1:0]  RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   localparam int                 AW          = addr_width(ENTRIES)
) (
   input  logic                              axil_aclk,
   input  logic                              axil_aresetn,
`ifdef REGFILE_SHADOW_EN
   input  logic                              commit,
`endif
   input  logic                              sys_en,
   input  logic                              sys_we,
   input  logic [AW-1:0]                     sys_addr,
   input  logic [DATA_WIDTH/8-1:0]           sys_wstrb,
   input  logic [DATA_WIDTH-1:0]             sys_din,
   output logic [DATA_WIDTH-1:0]             sys_dout,
   output logic                              sys_rvalid,
   output logic                              sys_err,
   input  logic [NUM_CLIENTS-1:0]            cli_rd,
   input  logic [NUM_CLIENTS*AW-1:0]         cli_addr,
   output logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_dout,
   output logic [NUM_CLIENTS-1:0]            cli_rvalid,
   output logic [ENTRIES-1:0]                reg_updated
);

   logic [1:0] rst_sync;
   logic       rst_n;
   logic [ENTRIES-1:0][DATA_WIDTH-1:0] active;
   logic [ENTRIES-1:0][DATA_WIDTH-1:0] sys_view;
   logic [ENTRIES-1:0][DATA_WIDTH-1:0] wr_next;
   logic sys_in_range;
   logic sys_ro;
   logic wr_ok;
   logic sys_rd;

   // Reset asserts immediately but releases on a clock edge.
   always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
      if (!axil_aresetn) rst_sync <= 2'b00;
      else               rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_comb begin
      sys_in_range = 1'b0;
      sys_ro       = 1'b0;
      for (int i = 0; i < ENTRIES; i++)
         if (int'(sys_addr) == i) begin
            sys_in_range = 1'b1;
            sys_ro       = RO_MASK[i];
         end
   end

   assign wr_ok  = sys_en & sys_we & sys_in_range & ~sys_ro;
   assign sys_rd = sys_en & ~sys_we;

   always_comb begin
      wr_next = sys_view;
      for (int i = 0; i < ENTRIES; i++)
         if (wr_ok && int'(sys_addr) == i)
            for (int b = 0; b < DATA_WIDTH/8; b++)
               if (sys_wstrb[b]) wr_next[i][b*8 +: 8] = sys_din[b*8 +: 8];
   end

   always_ff @(posedge axil_aclk or negedge rst_n) begin
      if (!rst_n) sys_err <= 1'b0;
      else        sys_err <= sys_en & (~sys_in_range | (sys_we & sys_ro));
   end

`ifdef REGFILE_SHADOW_EN
   logic [ENTRIES-1:0][DATA_WIDTH-1:0] shadow;
   assign sys_view = shadow;

   // Commit copies the pre-edge shadow, so a same-cycle write waits for the next commit.
   always_ff @(posedge axil_aclk or negedge rst_n) begin
      if (!rst_n) begin
         shadow      <= {ENTRIES{RESET_VALUE}};
         active      <= {ENTRIES{RESET_VALUE}};
         reg_updated <= '0;
      end else begin
         shadow      <= wr_next;
         reg_updated <= '0;
         if (commit) begin
            active <= shadow;
            for (int i = 0; i < ENTRIES; i++)
               reg_updated[i] <= (shadow[i] != active[i]);
         end
      end
   end
`else
   assign sys_view = active;

   always_ff @(posedge axil_aclk or negedge rst_n) begin
      if (!rst_n) begin
         active      <= {ENTRIES{RESET_VALUE}};
         reg_updated <= '0;
      end else begin
         active <= wr_next;
         for (int i = 0; i < ENTRIES; i++)
            reg_updated[i] <= wr_ok && (|sys_wstrb) && (int'(sys_addr) == i);
      end
   end
`endif

   regfile_read_port #(
      .ENTRIES(ENTRIES), .DATA_WIDTH(DATA_WIDTH), .AW(AW)
   ) u_sys_port (
      .clk   (axil_aclk),
      .rst_n (rst_n),
      .words (sys_view),
      .rd    (sys_rd),
      .addr  (sys_addr),
      .dout  (sys_dout),
      .rvalid(sys_rvalid)
   );

   for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_cli
      regfile_read_port #(
         .ENTRIES(ENTRIES), .DATA_WIDTH(DATA_WIDTH), .AW(AW)
      ) u_cli_port (
         .clk   (axil_aclk),
         .rst_n (rst_n),
         .words (active),
         .rd    (cli_rd[k]),
         .addr  (cli_addr[k*AW +: AW]),
         .dout  (cli_dout[k*DATA_WIDTH +: DATA_WIDTH]),
         .rvalid(cli_rvalid[k])
      );
   end

endmodule

// File: tb/tb_register_file_mc.sv
// Self-checking bench for register_file_mc: directed steps then random traffic,
// every cycle compared against a word-array model of the register file.
module tb_register_file_mc;

   localparam int ENTRIES = 12;
   localparam int DW      = 32;
   localparam int NC      = 2;
   localparam int AW      = 4;
   localparam logic [ENTRIES-1:0] RO = 12'h020;
   localparam logic [DW-1:0]      RV = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sys_en, sys_we;
   logic [AW-1:0]    sys_addr;
   logic [DW/8-1:0]  sys_wstrb;
   logic [DW-1:0]    sys_din;
   logic [DW-1:0]    sys_dout;
   logic             sys_rvalid, sys_err;
   logic [NC-1:0]    cli_rd;
   logic [NC*AW-1:0] cli_addr;
   logic [NC*DW-1:0] cli_dout;
   logic [NC-1:0]    cli_rvalid;
   logic [ENTRIES-1:0] reg_updated;
`ifdef REGFILE_SHADOW_EN
   logic commit;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: the words clients see, the words the system port sees,
   // and the last data returned on each read port.
   logic [DW-1:0] act [ENTRIES];
   logic [DW-1:0] shd [ENTRIES];
   logic [DW-1:0] last_sys;
   logic [DW-1:0] last_cli [NC];

   register_file_mc #(
      .ENTRIES(ENTRIES), .DATA_WIDTH(DW), .NUM_CLIENTS(NC),
      .RO_MASK(RO), .RESET_VALUE(RV)
   ) dut (
      .axil_aclk   (clk),
      .axil_aresetn(rst_n),
`ifdef REGFILE_SHADOW_EN
      .commit      (commit),
`endif
      .sys_en      (sys_en),
      .sys_we      (sys_we),
      .sys_addr    (sys_addr),
      .sys_wstrb   (sys_wstrb),
      .sys_din     (sys_din),
      .sys_dout    (sys_dout),
      .sys_rvalid  (sys_rvalid),
      .sys_err     (sys_err),
      .cli_rd      (cli_rd),
      .cli_addr    (cli_addr),
      .cli_dout    (cli_dout),
      .cli_rvalid  (cli_rvalid),
      .reg_updated (reg_updated)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         act[i] = RV;
         shd[i] = RV;
      end
      last_sys = '0;
      for (int k = 0; k < NC; k++) last_cli[k] = '0;
   endtask

   function automatic logic [DW-1:0] sysWord(input int a);
`ifdef REGFILE_SHADOW_EN
      return shd[a];
`else
      return act[a];
`endif
   endfunction

   task automatic idle();
      sys_en = 1'b0; sys_we = 1'b0; sys_addr = '0; sys_wstrb = '0; sys_din = '0;
      cli_rd = '0; cli_addr = '0;
`ifdef REGFILE_SHADOW_EN
      commit = 1'b0;
`endif
   endtask

   task automatic sysOp(input logic en, input logic we, input int addr,
                        input logic [3:0] strb, input logic [31:0] din);
      sys_en = en; sys_we = we; sys_addr = 4'(addr); sys_wstrb = strb; sys_din = din;
   endtask

   task automatic cliOp(input logic [1:0] rd, input int a0, input int a1);
      cli_rd = rd;
      cli_addr = {4'(a1), 4'(a0)};
   endtask

   // Predicts this cycle's responses from the model, clocks once, compares every output.
   task automatic applyStimulus();
      int a, ca;
      logic e_rv, e_err;
      logic [ENTRIES-1:0] e_upd;
      logic [DW-1:0] word;
      a = int'(sys_addr);
      e_rv = sys_en & ~sys_we;
      e_err = 1'b0;
      if (sys_en) begin
         if (a >= ENTRIES) e_err = 1'b1;
         else if (sys_we && RO[a]) e_err = 1'b1;
      end
      if (e_rv) last_sys = (a < ENTRIES) ? sysWord(a) : 32'h0;
      for (int k = 0; k < NC; k++)
         if (cli_rd[k]) begin
            ca = int'(cli_addr[k*AW +: AW]);
            last_cli[k] = (ca < ENTRIES) ? act[ca] : 32'h0;
         end
      e_upd = '0;
`ifdef REGFILE_SHADOW_EN
      if (commit)
         for (int i = 0; i < ENTRIES; i++) begin
            if (act[i] !== shd[i]) e_upd[i] = 1'b1;
            act[i] = shd[i];
         end
`endif
      if (sys_en && sys_we && a < ENTRIES && !RO[a] && sys_wstrb != 0) begin
         word = sysWord(a);
         for (int b = 0; b < DW/8; b++)
            if (sys_wstrb[b]) word[8*b +: 8] = sys_din[8*b +: 8];
`ifdef REGFILE_SHADOW_EN
         shd[a] = word;
`else
         act[a] = word;
         e_upd[a] = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
      checkOutput("sys_rvalid", 32'(sys_rvalid), 32'(e_rv));
      checkOutput("sys_dout", sys_dout, last_sys);
      checkOutput("sys_err", 32'(sys_err), 32'(e_err));
      checkOutput("reg_updated", 32'(reg_updated), 32'(e_upd));
      for (int k = 0; k < NC; k++) begin
         checkOutput($sformatf("cli%0d_rvalid", k), 32'(cli_rvalid[k]), 32'(cli_rd[k]));
         checkOutput($sformatf("cli%0d_dout", k), cli_dout[k*DW +: DW], last_cli[k]);
      end
   endtask

   initial begin
      idle();
      modelReset();
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_sys_dout", sys_dout, 32'h0);
      checkOutput("reset_sys_rvalid", 32'(sys_rvalid), 32'h0);
      checkOutput("reset_sys_err", 32'(sys_err), 32'h0);
      checkOutput("reset_reg_updated", 32'(reg_updated), 32'h0);
      checkOutput("reset_cli_rvalid", 32'(cli_rvalid), 32'h0);
      checkOutput("reset_cli0_dout", cli_dout[31:0], 32'h0);
      checkOutput("reset_cli1_dout", cli_dout[63:32], 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) applyStimulus();

      for (int i = 0; i < ENTRIES; i++) begin
         sysOp(1'b1, 1'b0, i, 4'h0, 32'h0);
         cliOp(2'b11, i, i);
         applyStimulus();
      end
      idle();
      applyStimulus();

      sysOp(1'b1, 1'b1, 3, 4'hF, 32'hAABBCCDD);
      applyStimulus();
      checkOutput("plan_upd3_first", 32'(reg_updated), 32'h008);
      sysOp(1'b1, 1'b1, 3, 4'h2, 32'h00001100);
      applyStimulus();
      checkOutput("plan_upd3_second", 32'(reg_updated), 32'h008);
      sysOp(1'b1, 1'b0, 3, 4'h0, 32'h0);
      applyStimulus();
      checkOutput("plan_addr3_merge", sys_dout, 32'hAABB11DD);
      sysOp(1'b1, 1'b1, 3, 4'h0, 32'hFFFFFFFF);
      applyStimulus();

      sysOp(1'b1, 1'b1, 5, 4'hF, 32'h12345678);
      applyStimulus();
      checkOutput("plan_ro_err", 32'(sys_err), 32'h1);
      checkOutput("plan_ro_no_upd", 32'(reg_updated), 32'h0);
      sysOp(1'b1, 1'b0, 5, 4'h0, 32'h0);
      applyStimulus();
      checkOutput("plan_ro_read", sys_dout, RV);

      idle();
      sysOp(1'b1, 1'b1, 2, 4'hF, 32'h1);
      cliOp(2'b01, 2, 0);
      applyStimulus();
      checkOutput("plan_collision_old", cli_dout[31:0], 32'h0);
      idle();
`ifdef REGFILE_SHADOW_EN
      commit = 1'b1;
      applyStimulus();
      commit = 1'b0;
`endif
      cliOp(2'b01, 2, 0);
      applyStimulus();
      checkOutput("plan_collision_new", cli_dout[31:0], 32'h1);

      sysOp(1'b1, 1'b0, 3, 4'h0, 32'h0);
      cliOp(2'b11, 3, 3);
      applyStimulus();
      sysOp(1'b1, 1'b0, 13, 4'h0, 32'h0);
      cliOp(2'b10, 0, 13);
      applyStimulus();
      checkOutput("plan_oor_sys_dout", sys_dout, 32'h0);
      checkOutput("plan_oor_sys_rvalid", 32'(sys_rvalid), 32'h1);
      checkOutput("plan_oor_sys_err", 32'(sys_err), 32'h1);
      checkOutput("plan_oor_cli1_dout", cli_dout[63:32], 32'h0);
      checkOutput("plan_oor_cli1_rvalid", 32'(cli_rvalid[1]), 32'h1);
      idle();
      sysOp(1'b1, 1'b1, 14, 4'hF, 32'hDEADBEEF);
      applyStimulus();

`ifdef REGFILE_SHADOW_EN
      idle();
      sysOp(1'b1, 1'b1, 0, 4'hF, 32'h5);
      applyStimulus();
      sysOp(1'b1, 1'b1, 1, 4'hF, 32'h6);
      applyStimulus();
      idle();
      cliOp(2'b11, 0, 1);
      applyStimulus();
      checkOutput("shadow_cli0_old", cli_dout[31:0], 32'h0);
      checkOutput("shadow_cli1_old", cli_dout[63:32], 32'h0);
      idle();
      commit = 1'b1;
      applyStimulus();
      commit = 1'b0;
      checkOutput("shadow_commit_upd", 32'(reg_updated), 32'h003);
      cliOp(2'b11, 0, 1);
      applyStimulus();
      checkOutput("shadow_cli0_new", cli_dout[31:0], 32'h5);
      checkOutput("shadow_cli1_new", cli_dout[63:32], 32'h6);
`endif

      for (int n = 0; n < 400; n++) begin
         sysOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom());
         cliOp(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
`ifdef REGFILE_SHADOW_EN
         commit = ($urandom_range(0, 7) == 0);
`endif
         applyStimulus();
      end

      sysOp(1'b1, 1'b0, 3, 4'h0, 32'h0);
      cliOp(2'b11, 4, 7);
      applyStimulus();
      rst_n = 1'b0;
      #2;
      checkOutput("midreset_sys_rvalid", 32'(sys_rvalid), 32'h0);
      checkOutput("midreset_sys_dout", sys_dout, 32'h0);
      checkOutput("midreset_cli_rvalid", 32'(cli_rvalid), 32'h0);
      checkOutput("midreset_cli0_dout", cli_dout[31:0], 32'h0);
      checkOutput("midreset_reg_updated", 32'(reg_updated), 32'h0);
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      repeat (3) applyStimulus();
      for (int i = 0; i < ENTRIES; i++) begin
         sysOp(1'b1, 1'b0, i, 4'h0, 32'h0);
         cliOp(2'b11, i, ENTRIES - 1 - i);
         applyStimulus();
      end
      idle();
      applyStimulus();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
